chimp_box_draw: RTL and testbench



---
 rtl/chimp_box_draw_if.sv | 27 ++
 rtl/chimp_box_draw.sv | 157 +++++++++++++++
 tb/tb_chimp_box_draw.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/chimp_box_draw_if.sv
// Request/pixel-stream bundle between the chimp game FSM (master) and the box
// renderer (slave); the pixel side feeds the VGA adapter's plot port.
interface chimp_box_draw_if #(
    parameter int COLOUR_W = 3
);
    logic                iStart;
    logic [2:0]          iBoxX;
    logic [2:0]          iBoxY;
    logic [COLOUR_W-1:0] iColour;
    logic [COLOUR_W-1:0] iBorderColour;
    logic [9:0]          oX;
    logic [8:0]          oY;
    logic [COLOUR_W-1:0] oColour;
    logic                oPlot;
    logic                oBusy;
    logic                oDone;

    modport master (
        output iStart, iBoxX, iBoxY, iColour, iBorderColour,
        input  oX, oY, oColour, oPlot, oBusy, oDone
    );

    modport slave (
        input  iStart, iBoxX, iBoxY, iColour, iBorderColour,
        output oX, oY, oColour, oPlot, oBusy, oDone
    );
endinterface

// File: rtl/chimp_box_draw.sv
// Rasterises one filled box of the 8x8 chimp-test grid, one plot per cycle, row-major.
// Define CHIMP_BOX_BORDER_EN to draw the box outline in the latched border colour.
module chimp_box_draw #(
    parameter int X_ORIGIN = 17,
    parameter int X_PITCH  = 37,
    parameter int Y_ORIGIN = 8,
    parameter int Y_PITCH  = 28,
    parameter int BOX_SIZE = 20,
    parameter int COLOUR_W = 3
) (
    input  logic             clk,
    input  logic             iReset,
    chimp_box_draw_if.slave  bus
);
    localparam int             CNT_W = 5;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BOX_SIZE - 1);

`ifdef CHIMP_BOX_BORDER_EN
    localparam bit BORDER_EN = 1'b1;
`else
    localparam bit BORDER_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    col_q, col_d;
    logic [CNT_W-1:0]    row_q, row_d;
    logic [9:0]          base_x_q, base_x_d;
    logic [8:0]          base_y_q, base_y_d;
    logic [COLOUR_W-1:0] fill_q, fill_d;
    logic [COLOUR_W-1:0] border_q, border_d;
    logic [9:0]          x_q, x_d;
    logic [8:0]          y_q, y_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic                plot_q, plot_d;
    logic                done_q, done_d;

    // Grid index times pitch as a fixed shift/add tree; no multiplier needed.
    function automatic logic [9:0] calc_base_x(input logic [2:0] bx);
        logic [9:0] p;
        p = 10'(X_PITCH);
        return 10'(X_ORIGIN) + (bx[0] ? p : 10'd0) + (bx[1] ? (p << 1) : 10'd0)
                             + (bx[2] ? (p << 2) : 10'd0);
    endfunction

    function automatic logic [8:0] calc_base_y(input logic [2:0] by);
        logic [8:0] p;
        p = 9'(Y_PITCH);
        return 9'(Y_ORIGIN) + (by[0] ? p : 9'd0) + (by[1] ? (p << 1) : 9'd0)
                            + (by[2] ? (p << 2) : 9'd0);
    endfunction

    function automatic logic [COLOUR_W-1:0] pick_colour(
        input logic [CNT_W-1:0]    c,
        input logic [CNT_W-1:0]    r,
        input logic [COLOUR_W-1:0] fill,
        input logic [COLOUR_W-1:0] border
    );
        if (BORDER_EN && (c == '0 || c == LAST || r == '0 || r == LAST)) return border;
        return fill;
    endfunction

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        base_x_d = base_x_q;
        base_y_d = base_y_q;
        fill_d   = fill_q;
        border_d = border_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.iStart) begin
                    state_d  = DRAW;
                    col_d    = '0;
                    row_d    = '0;
                    base_x_d = calc_base_x(bus.iBoxX);
                    base_y_d = calc_base_y(bus.iBoxY);
                    fill_d   = bus.iColour;
                    border_d = bus.iBorderColour;
                    x_d      = base_x_d;
                    y_d      = base_y_d;
                    colour_d = pick_colour('0, '0, bus.iColour, bus.iBorderColour);
                    plot_d   = 1'b1;
                end
            end
            DRAW: begin
                if (col_q == LAST && row_q == LAST) begin
                    state_d = DONE;
                    col_d   = '0;
                    row_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    if (col_q == LAST) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    x_d      = base_x_q + 10'(col_d);
                    y_d      = base_y_q + 9'(row_d);
                    colour_d = pick_colour(col_d, row_d, fill_q, border_q);
                    plot_d   = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments so every flop samples
    // pre-edge values; the async reset clears the whole datapath, not just the FSM.
    always_ff @(posedge clk or posedge iReset) begin
        if (iReset) begin
            state_q  <= IDLE;
            col_q    <= '0;
            row_q    <= '0;
            base_x_q <= '0;
            base_y_q <= '0;
            fill_q   <= '0;
            border_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            base_x_q <= base_x_d;
            base_y_q <= base_y_d;
            fill_q   <= fill_d;
            border_q <= border_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            done_q   <= done_d;
        end
    end

    // Busy and plot coincide cycle for cycle, so one flop serves both.
    assign bus.oX      = x_q;
    assign bus.oY      = y_q;
    assign bus.oColour = colour_q;
    assign bus.oPlot   = plot_q;
    assign bus.oBusy   = plot_q;
    assign bus.oDone   = done_q;
endmodule

// File: tb/tb_chimp_box_draw.sv
// Scoreboard bench for chimp_box_draw: expected pixels are queued at start and popped per plot.
// Honours CHIMP_BOX_BORDER_EN the same way the design does.
module tb_chimp_box_draw;
    localparam int N = 20;

`ifdef CHIMP_BOX_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic [2:0] c;
    } pix_t;

    logic clk = 1'b0;
    logic iReset = 1'b0;
    always #5 clk = ~clk;

    chimp_box_draw_if #(.COLOUR_W(3)) bus ();

    chimp_box_draw dut (
        .clk    (clk),
        .iReset (iReset),
        .bus    (bus)
    );

    pix_t exp_q[$];
    pix_t seen_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic run_box(input string name, input logic [2:0] bx, input logic [2:0] by,
                           input logic [2:0] col, input logic [2:0] bcol, input bit disturb);
        int   plots = 0;
        int   cycles = 0;
        bit   done_seen = 1'b0;
        pix_t e, got;
        seen_q.delete();
        exp_q.delete();
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                e.x = 10'(17 + 37 * int'(bx) + c);
                e.y = 9'(8 + 28 * int'(by) + r);
                e.c = (BORDER && (r == 0 || r == N-1 || c == 0 || c == N-1)) ? bcol : col;
                exp_q.push_back(e);
            end
        end
        bus.iBoxX = bx;
        bus.iBoxY = by;
        bus.iColour = col;
        bus.iBorderColour = bcol;
        bus.iStart = 1'b1;
        @(negedge clk);
        bus.iStart = 1'b0;
        while (!done_seen && cycles < N*N + 20) begin
            n_checks++;
            if (bus.oBusy !== bus.oPlot) begin
                n_fail++;
                $display("FAIL %s busy_vs_plot: oBusy=%b oPlot=%b (must match)", name, bus.oBusy, bus.oPlot);
            end
            n_checks++;
            if (bus.oPlot !== 1'b1 && bus.oDone !== 1'b1) begin
                n_fail++;
                $display("FAIL %s plot_gap: oPlot=%b oDone=%b after %0d plots, required plot or done",
                         name, bus.oPlot, bus.oDone, plots);
            end
            if (bus.oPlot === 1'b1) begin
                got = '{bus.oX, bus.oY, bus.oColour};
                seen_q.push_back(got);
                plots++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s extra_plot: got (%0d,%0d,c%0d), required no plot", name, got.x, got.y, got.c);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_fail++;
                        $display("FAIL %s pixel%0d: got (%0d,%0d,c%0d), required (%0d,%0d,c%0d)",
                                 name, plots-1, got.x, got.y, got.c, e.x, e.y, e.c);
                    end
                end
                if (disturb && plots == 5) begin
                    bus.iStart = 1'b1;
                    bus.iBoxX = 3'd5;
                    bus.iBoxY = 3'd5;
                    bus.iColour = ~col;
                    bus.iBorderColour = ~bcol;
                end else if (disturb && plots == 6) begin
                    bus.iStart = 1'b0;
                end
            end else if (bus.oDone === 1'b1) begin
                done_seen = 1'b1;
            end
            if (!done_seen) @(negedge clk);
            cycles++;
        end
        n_checks++;
        if (!done_seen) begin
            n_fail++;
            $display("FAIL %s done_timeout: no oDone within %0d cycles", name, N*N + 20);
        end
        n_checks++;
        if (plots != N*N) begin
            n_fail++;
            $display("FAIL %s plot_count: got %0d, required %0d", name, plots, N*N);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s missing_pixels: %0d not plotted, required 0", name, exp_q.size());
        end
        exp_q.delete();
        if (disturb) bus.iStart = 1'b1;
        @(negedge clk);
        bus.iStart = 1'b0;
        n_checks++;
        if (bus.oDone !== 1'b0 || bus.oPlot !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after_done: oDone=%b oPlot=%b, required 0 0", name, bus.oDone, bus.oPlot);
        end
    endtask

    task automatic check_pix(input string name, input int idx, input int x, input int y, input int c);
        n_checks++;
        if (seen_q.size() <= idx) begin
            n_fail++;
            $display("FAIL %s: pixel %0d not observed, required (%0d,%0d)", name, idx, x, y);
        end else if (seen_q[idx].x !== 10'(x) || seen_q[idx].y !== 9'(y) ||
                     (c >= 0 && seen_q[idx].c !== 3'(c))) begin
            n_fail++;
            $display("FAIL %s: got (%0d,%0d,c%0d), required (%0d,%0d,c%0d)",
                     name, seen_q[idx].x, seen_q[idx].y, seen_q[idx].c, x, y, c);
        end
    endtask

    task automatic test_reset();
        #2 iReset = 1'b1;
        #1;
        n_checks++;
        if (bus.oPlot !== 1'b0 || bus.oBusy !== 1'b0 || bus.oDone !== 1'b0 ||
            bus.oX !== 10'd0 || bus.oY !== 9'd0 || bus.oColour !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_async: oX=%0d oY=%0d oC=%0d plot=%b busy=%b done=%b, required all 0",
                     bus.oX, bus.oY, bus.oColour, bus.oPlot, bus.oBusy, bus.oDone);
        end
        repeat (2) @(negedge clk);
        iReset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            n_checks++;
            if (bus.oPlot !== 1'b0 || bus.oDone !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle: oPlot=%b oDone=%b, required 0 0", bus.oPlot, bus.oDone);
            end
        end
    endtask

    task automatic test_first_box();
        run_box("box00", 3'd0, 3'd0, 3'b100, 3'b100, 1'b0);
        check_pix("box00_first", 0, 17, 8, 4);
        check_pix("box00_last", 399, 36, 27, 4);
    endtask

    task automatic test_corner_box();
        run_box("box77", 3'd7, 3'd7, 3'b010, 3'b010, 1'b0);
        check_pix("box77_first", 0, 276, 204, -1);
        check_pix("box77_20th", 19, 295, 204, -1);
        check_pix("box77_21st", 20, 276, 205, -1);
        check_pix("box77_last", 399, 295, 223, -1);
    endtask

    task automatic test_ignore_inputs();
        int bad = 0;
        run_box("box32_disturbed", 3'd3, 3'd2, 3'b011, 3'b101, 1'b1);
        foreach (seen_q[i]) begin
            if (seen_q[i].x < 10'd128 || seen_q[i].x > 10'd147 ||
                seen_q[i].y < 9'd64 || seen_q[i].y > 9'd83) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL box32_range: %0d pixels outside x128..147 y64..83, required 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        run_box("box55_b2b", 3'd5, 3'd5, 3'b110, 3'b001, 1'b0);
        check_pix("box55_first", 0, 202, 148, -1);
    endtask

    task automatic test_reset_mid_draw();
        int plots = 0;
        int cycles = 0;
        bus.iBoxX = 3'd1;
        bus.iBoxY = 3'd1;
        bus.iColour = 3'b111;
        bus.iStart = 1'b1;
        @(negedge clk);
        bus.iStart = 1'b0;
        while (plots < 100 && cycles < 200) begin
            if (bus.oPlot === 1'b1) plots++;
            if (plots < 100) @(negedge clk);
            cycles++;
        end
        n_checks++;
        if (plots != 100) begin
            n_fail++;
            $display("FAIL midreset_reach100: got %0d plots, required 100", plots);
        end
        iReset = 1'b1;
        #1;
        n_checks++;
        if (bus.oPlot !== 1'b0 || bus.oBusy !== 1'b0 || bus.oDone !== 1'b0 || bus.oX !== 10'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: plot=%b busy=%b done=%b oX=%0d, required 0",
                     bus.oPlot, bus.oBusy, bus.oDone, bus.oX);
        end
        repeat (2) @(negedge clk);
        iReset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            n_checks++;
            if (bus.oPlot !== 1'b0 || bus.oDone !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_quiet: oPlot=%b oDone=%b, required 0 0", bus.oPlot, bus.oDone);
            end
        end
        run_box("after_midreset", 3'd2, 3'd6, 3'b001, 3'b010, 1'b0);
    endtask

    task automatic test_border();
        int edge_c;
        edge_c = BORDER ? 6 : 1;
        run_box("border32", 3'd3, 3'd2, 3'd1, 3'd6, 1'b0);
        check_pix("border_tl", 0, 128, 64, edge_c);
        check_pix("border_br", 399, 147, 83, edge_c);
        check_pix("border_inner", 21, 129, 65, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.iStart = 1'b0;
        bus.iBoxX = '0;
        bus.iBoxY = '0;
        bus.iColour = '0;
        bus.iBorderColour = '0;
        test_reset();
        test_first_box();
        test_corner_box();
        test_ignore_inputs();
        test_back_to_back();
        test_reset_mid_draw();
        test_border();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
